// File: rtl/wormhole_pkg.sv
// Shared types and screen defaults for the wormhole teleport controller.
package wormhole_pkg;

   localparam int SCREEN_W_DEFAULT = 640;
   localparam int SCREEN_H_DEFAULT = 480;

   typedef logic signed [10:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_COOLDOWN
   } state_t;

endpackage

// File: rtl/wormhole_teleport_ctrl_if.sv
// Frame/pixel inputs and teleport handshake of the wormhole teleport controller.
// Optional cheat-exit signals exist only when WORMHOLE_CHEAT_EN is defined.
interface wormhole_teleport_ctrl_if;
   import wormhole_pkg::*;

   logic   startOfFrame;
   logic   shipDrawingRequest;
   logic   wormhole1DrawingRequest;
   logic   wormhole2DrawingRequest;
   coord_t wormhole1TopLeftX;
   coord_t wormhole1TopLeftY;
   coord_t wormhole2TopLeftX;
   coord_t wormhole2TopLeftY;
   logic   teleportAck;
   logic   teleportReq;
   coord_t teleportX;
   coord_t teleportY;
   logic   cooldownActive;
`ifdef WORMHOLE_CHEAT_EN
   logic   wormholeCheat;
   coord_t cheatTopLeftX;
   coord_t cheatTopLeftY;

   modport master (
      output startOfFrame, shipDrawingRequest, wormhole1DrawingRequest, wormhole2DrawingRequest,
      output wormhole1TopLeftX, wormhole1TopLeftY, wormhole2TopLeftX, wormhole2TopLeftY,
      output teleportAck, wormholeCheat, cheatTopLeftX, cheatTopLeftY,
      input  teleportReq, teleportX, teleportY, cooldownActive
   );
   modport slave (
      input  startOfFrame, shipDrawingRequest, wormhole1DrawingRequest, wormhole2DrawingRequest,
      input  wormhole1TopLeftX, wormhole1TopLeftY, wormhole2TopLeftX, wormhole2TopLeftY,
      input  teleportAck, wormholeCheat, cheatTopLeftX, cheatTopLeftY,
      output teleportReq, teleportX, teleportY, cooldownActive
   );
`else
   modport master (
      output startOfFrame, shipDrawingRequest, wormhole1DrawingRequest, wormhole2DrawingRequest,
      output wormhole1TopLeftX, wormhole1TopLeftY, wormhole2TopLeftX, wormhole2TopLeftY,
      output teleportAck,
      input  teleportReq, teleportX, teleportY, cooldownActive
   );
   modport slave (
      input  startOfFrame, shipDrawingRequest, wormhole1DrawingRequest, wormhole2DrawingRequest,
      input  wormhole1TopLeftX, wormhole1TopLeftY, wormhole2TopLeftX, wormhole2TopLeftY,
      input  teleportAck,
      output teleportReq, teleportX, teleportY, cooldownActive
   );
`endif

endinterface

// File: rtl/wormhole_clamp.sv
// Combinational exit-position adder: base + offset in 12-bit signed, clamped to the screen.
module wormhole_clamp
   import wormhole_pkg::*;
#(
   parameter int OFFSET_X = 40,
   parameter int OFFSET_Y = 0,
   parameter int SCREEN_W = SCREEN_W_DEFAULT,
   parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
   input  coord_t base_x,
   input  coord_t base_y,
   output coord_t dest_x,
   output coord_t dest_y
);

   localparam logic signed [11:0] OFF_X = 12'(OFFSET_X);
   localparam logic signed [11:0] OFF_Y = 12'(OFFSET_Y);
   localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - 1);

   logic signed [11:0] sum_x;
   logic signed [11:0] sum_y;

   // Sign-extend by one bit so base+offset cannot overflow before clamping
   assign sum_x = $signed({base_x[10], base_x}) + OFF_X;
   assign sum_y = $signed({base_y[10], base_y}) + OFF_Y;

   always_comb begin
      dest_x = coord_t'(sum_x[10:0]);
      dest_y = coord_t'(sum_y[10:0]);
      if (sum_x[11]) begin
         dest_x = '0;
      end else if (sum_x > MAX_X) begin
         dest_x = coord_t'(MAX_X[10:0]);
      end
      if (sum_y[11]) begin
         dest_y = '0;
      end else if (sum_y > MAX_Y) begin
         dest_y = coord_t'(MAX_Y[10:0]);
      end
   end

endmodule

// File: rtl/wormhole_teleport_ctrl.sv
// Detects ship/wormhole overlap per frame, requests a teleport to the opposite wormhole, then cools down.
// Optional feature macro: WORMHOLE_CHEAT_EN (cheat exit position for wormhole1 entries).
module wormhole_teleport_ctrl
   import wormhole_pkg::*;
#(
   parameter int COOLDOWN_FRAMES = 60,
   parameter int EXIT_OFFSET_X   = 40,
   parameter int EXIT_OFFSET_Y   = 0,
   parameter int SCREEN_W        = SCREEN_W_DEFAULT,
   parameter int SCREEN_H        = SCREEN_H_DEFAULT
) (
   input logic clk,
   input logic resetN,
   wormhole_teleport_ctrl_if.slave bus
);

   localparam int CNT_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

   state_t           state_q, state_d;
   logic             hit1_q, hit1_d;
   logic             hit2_q, hit2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   coord_t           tx_q, tx_d;
   coord_t           ty_q, ty_d;
   coord_t           base_x, base_y;
   coord_t           clamp_x, clamp_y;
   logic             ovl1, ovl2;

   assign ovl1 = bus.shipDrawingRequest & bus.wormhole1DrawingRequest;
   assign ovl2 = bus.shipDrawingRequest & bus.wormhole2DrawingRequest;

   // Entering wormhole1 exits at wormhole2 and vice versa; wormhole1 wins ties
   always_comb begin
      base_x = bus.wormhole1TopLeftX;
      base_y = bus.wormhole1TopLeftY;
      if (hit1_q) begin
`ifdef WORMHOLE_CHEAT_EN
         if (bus.wormholeCheat) begin
            base_x = bus.cheatTopLeftX;
            base_y = bus.cheatTopLeftY;
         end else begin
            base_x = bus.wormhole2TopLeftX;
            base_y = bus.wormhole2TopLeftY;
         end
`else
         base_x = bus.wormhole2TopLeftX;
         base_y = bus.wormhole2TopLeftY;
`endif
      end
   end

   wormhole_clamp #(
      .OFFSET_X (EXIT_OFFSET_X),
      .OFFSET_Y (EXIT_OFFSET_Y),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clamp (
      .base_x (base_x),
      .base_y (base_y),
      .dest_x (clamp_x),
      .dest_y (clamp_y)
   );

   always_comb begin
      state_d = state_q;
      hit1_d  = hit1_q | ovl1;
      hit2_d  = hit2_q | ovl2;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.startOfFrame) begin
               // Overlap seen on the frame-start cycle belongs to the new frame
               hit1_d = ovl1;
               hit2_d = ovl2;
               if (hit1_q || hit2_q) begin
                  state_d = ST_REQUEST;
                  tx_d    = clamp_x;
                  ty_d    = clamp_y;
               end
            end
         end
         ST_REQUEST: begin
            hit1_d = 1'b0;
            hit2_d = 1'b0;
            if (bus.teleportAck) begin
               state_d = ST_COOLDOWN;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_COOLDOWN: begin
            hit1_d = 1'b0;
            hit2_d = 1'b0;
            if (bus.startOfFrame) begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            hit1_d  = 1'b0;
            hit2_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         hit1_q  <= 1'b0;
         hit2_q  <= 1'b0;
         cnt_q   <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
      end else begin
         state_q <= state_d;
         hit1_q  <= hit1_d;
         hit2_q  <= hit2_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
      end
   end

   assign bus.teleportReq    = (state_q == ST_REQUEST);
   assign bus.cooldownActive = (state_q == ST_COOLDOWN);
   assign bus.teleportX      = tx_q;
   assign bus.teleportY      = ty_q;

endmodule

// File: doc/wormhole_teleport_ctrl.md
WORMHOLE_TELEPORT_CTRL -- requirements
Module: wormhole_teleport_ctrl

Interface
REQ-001 Parameters SHALL be: COOLDOWN_FRAMES, default 60, frames during which teleport is blocked after a completed teleport; EXIT_OFFSET_X, default 40, signed X displacement from the exit wormhole top-left; EXIT_OFFSET_Y, default 0, signed Y displacement; SCREEN_W, default 640; SCREEN_H, default 480.
REQ-002 clk  in  1  system clock.
REQ-003 resetN  in  1  reset, asynchronous, active-low.
REQ-004 startOfFrame  in  1  one-cycle pulse at frame start.
REQ-005 shipDrawingRequest  in  1  spaceship pixel active.
REQ-006 wormhole1DrawingRequest, wormhole2DrawingRequest  in  1 each  wormhole pixel active.
REQ-007 wormhole1TopLeftX/Y, wormhole2TopLeftX/Y  in  signed 11 each  current wormhole positions.
REQ-008 teleportAck  in  1  ship controller has taken the new position.
REQ-009 teleportReq  out  1  new ship position valid.
REQ-010 teleportX, teleportY  out  signed 11  ship destination top-left.
REQ-011 cooldownActive  out  1  high in COOLDOWN.

Function
REQ-012 During a frame, hit1 SHALL set on any cycle where shipDrawingRequest and wormhole1DrawingRequest are both 1; hit2 likewise for wormhole2.
REQ-013 States SHALL be IDLE, REQUEST, COOLDOWN.
REQ-014 IDLE, on startOfFrame: if hit1, the block SHALL go to REQUEST with wormhole2 as the exit; else if hit2, it SHALL go to REQUEST with wormhole1 as the exit; else it SHALL stay in IDLE. hit1 and hit2 SHALL clear in the same cycle.
REQ-015 When hit1 and hit2 are both set, wormhole1 entry SHALL win.
REQ-016 A drawing-request overlap in the same cycle as startOfFrame SHALL count toward the new frame, not the frame being evaluated.
REQ-017 On entering REQUEST, teleportX/Y SHALL be computed once as exit top-left plus EXIT_OFFSET_X/Y, using 12-bit signed arithmetic.
REQ-018 teleportX SHALL be clamped to 0..SCREEN_W-1 and teleportY to 0..SCREEN_H-1.
REQ-019 teleportX/Y SHALL stay stable until the ack; later wormhole position changes SHALL be ignored.
REQ-020 In REQUEST, teleportReq SHALL be 1; it SHALL deassert the cycle after teleportAck is sampled high.
REQ-021 On the ack, the state SHALL become COOLDOWN and the counter SHALL load COOLDOWN_FRAMES.
REQ-022 teleportAck outside REQUEST SHALL be ignored.
REQ-023 teleportReq SHALL assert one cycle after the evaluating startOfFrame.
REQ-024 In REQUEST, hit flags SHALL stay cleared and startOfFrame SHALL be ignored.
REQ-025 In COOLDOWN, each startOfFrame SHALL decrement the counter, and hits SHALL be ignored and kept cleared.
REQ-026 When the counter is 0 at a startOfFrame, the state SHALL return to IDLE.
REQ-027 COOLDOWN_FRAMES=0 SHALL return to IDLE at the first startOfFrame after the ack.
REQ-028 The counter SHALL be $clog2(COOLDOWN_FRAMES+1) bits wide, minimum 1, and SHALL never wrap.

Reset
REQ-029 On resetN low, the block SHALL go to IDLE with teleportReq=0, teleportX/Y=0, cooldownActive=0, hit flags=0 and counter=0, immediately and regardless of state, including mid-REQUEST.
REQ-030 After reset release, the first startOfFrame SHALL evaluate only hits seen since the release.

Configuration
REQ-031 Macro WORMHOLE_CHEAT_EN defined: the block SHALL add ports wormholeCheat (in, 1) and cheatTopLeftX/Y (in, signed 11).
REQ-032 With WORMHOLE_CHEAT_EN defined and wormholeCheat=1 at destination latch time, the exit base for a wormhole1 entry SHALL be cheatTopLeftX/Y instead of wormhole2TopLeftX/Y.
REQ-033 With WORMHOLE_CHEAT_EN undefined, these ports SHALL not exist and the exit SHALL always be the opposite wormhole.

Structure
REQ-034 Package wormhole_pkg SHALL hold the state enum, SCREEN_W/H defaults and the coordinate typedef (signed 11-bit).
REQ-035 Sub-module wormhole_clamp SHALL implement the combinational add-and-clamp; everything else SHALL be in the top.

Verification
REQ-036 Ship overlaps wormhole1 (wormhole2 at 300,200) -> at next startOfFrame+1: teleportReq=1, teleportX=340, teleportY=200.
REQ-037 Both hits in one frame -> exit = wormhole2; wormhole2 at 620,470 with offset 40 -> teleportX=639 (clamped), teleportY=470.
REQ-038 Ack 3 cycles after req -> req falls the next cycle; overlaps during the next 60 frames -> no req; overlap in frame 62 -> req.
REQ-039 resetN low while teleportReq=1 -> outputs 0 at once; no req after release without a new overlap.
REQ-040 Macro on, wormholeCheat=1, cheat at 100,50, hit1 -> teleportX=140, teleportY=50.
REQ-041 Overlap only in the same cycle as startOfFrame -> no req at that edge; req after the following startOfFrame.
